// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, external and memory-side signals around the data-memory arbiter.
// slave: arbiter view; master: requesters and RAM view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data RAM between the CPU MEM stage
// and an external loader/debug port; stalls the CPU until its access completes.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {CPU = 1'b0, EXT = 1'b1} owner_t;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    owner_t            last_owner;
    owner_t            grant;
    logic              grant_vld;
    logic [2:0]        cnt;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;

    // On contention the requester that did not own the previous access wins.
    always_comb begin
        grant_vld = bus.cpu_req | bus.ext_req;
        if (bus.cpu_req && bus.ext_req) begin
            grant = (last_owner == CPU) ? EXT : CPU;
        end else if (bus.cpu_req) begin
            grant = CPU;
        end else begin
            grant = EXT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en    = (state == ISSUE);
        bus.ext_ack   = (state == RESP) && (owner == EXT);
        bus.cpu_stall = bus.cpu_req & ~((state == RESP) && (owner == CPU));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= CPU;
            last_owner  <= EXT;
            cnt         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner      <= grant;
                        last_owner <= grant;
                        if (grant == CPU) begin
                            mem_we_q    <= bus.cpu_we;
                            mem_addr_q  <= bus.cpu_addr;
                            mem_wdata_q <= bus.cpu_wdata;
                        end else begin
                            mem_we_q    <= bus.ext_we;
                            mem_addr_q  <= bus.ext_addr;
                            mem_wdata_q <= bus.ext_wdata;
                        end
                    end
                end
                ISSUE: cnt <= CNT_LOAD;
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 3'd1;
                    end else if (owner == CPU) begin
                        cpu_rdata_q <= bus.mem_rdata;
                    end else begin
                        ext_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ext_rdata = ext_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a latency-accurate RAM, directed scenarios,
// then randomized concurrent CPU/EXT traffic checked against a reference memory array.
module tb_dmem_arbiter;
    localparam int LAT = 3;
    localparam int P   = LAT + 3;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        cpu_q[$];
    exp_t        ext_q[$];
    exp_t        mon_e;
    logic [31:0] refmem [64];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int unsigned i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'h9E37_79B9 * (i + 1));
    endfunction

    // RAM with fixed read latency; reads return a poison word outside their valid cycle.
    logic [31:0] ram [64];
    logic        written [64];
    logic [31:0] pd [LAT];
    logic        pv [LAT];
    logic        mem_init = 1'b0;
    logic [5:0]  midx;
    assign midx = bus.mem_addr[7:2];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) written[i] <= 1'b0;
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
            mem_init <= 1'b1;
        end else begin
            if (bus.mem_en && bus.mem_we) begin
                ram[midx]     <= bus.mem_wdata;
                written[midx] <= 1'b1;
            end
            pd[0] <= written[midx] ? ram[midx] : seed_word(32'(midx));
            pv[0] <= bus.mem_en && !bus.mem_we;
            for (int i = 1; i < LAT; i++) begin
                pd[i] <= pd[i-1];
                pv[i] <= pv[i-1];
            end
        end
    end
    assign bus.mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'h0BAD_F00D;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int limit);
        vectors++;
        if (act > limit) begin
            miscompares++;
            $display("FAIL %s: got %0d cycles, expected at most %0d", name, act, limit);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a requester sees completion.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cpu_req && !bus.cpu_stall) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_resp_pending", 32'(cpu_q.size()), 32'd1);
                end else begin
                    mon_e = cpu_q.pop_front();
                    if (mon_e.chk) check("cpu_rdata", bus.cpu_rdata, mon_e.data);
                end
            end
            if (bus.ext_ack) begin
                if (ext_q.size() == 0) begin
                    check("ext_ack_pending", 32'(ext_q.size()), 32'd1);
                end else begin
                    mon_e = ext_q.pop_front();
                    if (mon_e.chk) check("ext_rdata", bus.ext_rdata, mon_e.data);
                end
            end
        end
    end

    function automatic exp_t expect_access(input logic we, input logic [31:0] addr,
                                           input logic [31:0] wdata);
        exp_t e;
        e.chk  = !we;
        e.data = refmem[addr[7:2]];
        if (we) refmem[addr[7:2]] = wdata;
        return e;
    endfunction

    task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int n);
        cpu_q.push_back(expect_access(we, addr, wdata));
        bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.cpu_stall) break;
            n++;
            if (n > 4 * P) begin
                check_le("cpu_stall_timeout", n, 4 * P);
                break;
            end
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic ext_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int n);
        ext_q.push_back(expect_access(we, addr, wdata));
        bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wdata; bus.ext_req = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.ext_ack) break;
            n++;
            if (n > 4 * P) begin
                check_le("ext_ack_timeout", n, 4 * P);
                break;
            end
        end
        @(posedge clk); #1;
        bus.ext_req = 1'b0;
    endtask

    task automatic cpu_random(input int unsigned count);
        int n;
        for (int unsigned k = 0; k < count; k++) begin
            cpu_txn(1'($urandom_range(0, 1)), 32'h80 + 32'(4 * $urandom_range(0, 15)), $urandom, n);
            check_le("cpu_grant_wait", n, 2 * P - 1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic ext_random(input int unsigned count);
        int n;
        for (int unsigned k = 0; k < count; k++) begin
            ext_txn(1'($urandom_range(0, 1)), 32'hC0 + 32'(4 * $urandom_range(0, 15)), $urandom, n);
            check_le("ext_grant_wait", n, 2 * P - 1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int unsigned i = 0; i < 64; i++) refmem[i] = seed_word(i);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;

        // Reset values; stall follows cpu_req while reset is held.
        @(negedge clk);
        check1("rst_mem_en", bus.mem_en, 1'b0);
        check1("rst_ext_ack", bus.ext_ack, 1'b0);
        check1("rst_stall", bus.cpu_stall, 1'b1);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        bus.cpu_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single CPU read of 0x10.
        cpu_q.push_back(expect_access(1'b0, 32'h10, 32'h0));
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_req = 1'b1;
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            check1("rd_mem_en", bus.mem_en, 1'(c == 1));
            if (c == 1) check("rd_mem_addr", bus.mem_addr, 32'h10);
            check1("rd_stall", bus.cpu_stall, 1'(c != P - 1));
        end
        @(posedge clk); #1 bus.cpu_req = 1'b0;

        // External write of 0x40, then a CPU read-back.
        ext_q.push_back(expect_access(1'b1, 32'h40, 32'h1234_5678));
        bus.ext_we = 1'b1; bus.ext_addr = 32'h40; bus.ext_wdata = 32'h1234_5678; bus.ext_req = 1'b1;
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            check1("ewr_mem_en", bus.mem_en, 1'(c == 1));
            if (c == 1) begin
                check1("ewr_mem_we", bus.mem_we, 1'b1);
                check("ewr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
            end
            check1("ewr_ack", bus.ext_ack, 1'(c == P - 1));
        end
        @(posedge clk); #1 bus.ext_req = 1'b0;
        cpu_txn(1'b0, 32'h40, 32'h0, n);
        check("cpu_rd_latency", 32'(n), 32'(P - 1));

        // Continuous contention from reset: CPU, EXT, CPU.
        apply_reset();
        cpu_q.push_back(expect_access(1'b0, 32'h30, 32'h0));
        cpu_q.push_back(expect_access(1'b0, 32'h30, 32'h0));
        ext_q.push_back(expect_access(1'b0, 32'h34, 32'h0));
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h30; bus.cpu_req = 1'b1;
        bus.ext_we = 1'b0; bus.ext_addr = 32'h34; bus.ext_req = 1'b1;
        for (int c = 0; c < 3 * P; c++) begin
            @(negedge clk);
            check1("rr_mem_en", bus.mem_en, 1'(c == 1 || c == P + 1 || c == 2 * P + 1));
            if (c == 1 || c == 2 * P + 1) check("rr_cpu_addr", bus.mem_addr, 32'h30);
            if (c == P + 1) check("rr_ext_addr", bus.mem_addr, 32'h34);
            check1("rr_stall", bus.cpu_stall, 1'(!(c == P - 1 || c == 3 * P - 1)));
            if (c == 2 * P - 1) begin @(posedge clk); #1 bus.ext_req = 1'b0; end
        end
        @(posedge clk); #1 bus.cpu_req = 1'b0;

        // CPU write of 0x20 abandoned in the ISSUE cycle still commits exactly once.
        refmem[8] = 32'hA5A5_5A5A;
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'hA5A5_5A5A; bus.cpu_req = 1'b1;
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        for (int c = 1; c <= P + 3; c++) begin
            @(negedge clk);
            check1("flush_mem_en", bus.mem_en, 1'(c == 1));
            if (c == 1) begin
                check("flush_mem_addr", bus.mem_addr, 32'h20);
                check1("flush_mem_we", bus.mem_we, 1'b1);
            end
        end
        @(posedge clk); #1;
        cpu_txn(1'b0, 32'h20, 32'h0, n);

        // Address change after grant is ignored.
        cpu_q.push_back(expect_access(1'b0, 32'h8, 32'h0));
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h8; bus.cpu_req = 1'b1;
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            if (c >= 1) check("hold_mem_addr", bus.mem_addr, 32'h8);
            check1("hold_stall", bus.cpu_stall, 1'(c != P - 1));
            if (c == 0) begin @(posedge clk); #1 bus.cpu_addr = 32'hC; end
        end
        @(posedge clk); #1 bus.cpu_req = 1'b0;

        // Reset pulse during WAIT of an EXT read; fresh grant right after release.
        bus.ext_we = 1'b0; bus.ext_addr = 32'h44; bus.ext_req = 1'b1;
        @(posedge clk); @(posedge clk); #3;
        bus.cpu_req = 1'b1; rst_n = 1'b0;
        #1;
        check1("arst_mem_en", bus.mem_en, 1'b0);
        check1("arst_ext_ack", bus.ext_ack, 1'b0);
        check1("arst_mem_we", bus.mem_we, 1'b0);
        check1("arst_stall", bus.cpu_stall, 1'b1);
        check("arst_mem_addr", bus.mem_addr, 32'h0);
        check("arst_mem_wdata", bus.mem_wdata, 32'h0);
        check("arst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("arst_ext_rdata", bus.ext_rdata, 32'h0);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        ext_q.push_back(expect_access(1'b0, 32'h44, 32'h0));
        rst_n = 1'b1;
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            check1("regrant_mem_en", bus.mem_en, 1'(c == 1));
            if (c == 1) check("regrant_mem_addr", bus.mem_addr, 32'h44);
            check1("regrant_ack", bus.ext_ack, 1'(c == P - 1));
        end
        @(posedge clk); #1 bus.ext_req = 1'b0;

        // Concurrent randomized traffic on disjoint address windows.
        fork
            cpu_random(40);
            ext_random(40);
        join
        repeat (3) @(posedge clk);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("ext_q_drained", 32'(ext_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
